// File: rtl/serial_adder_driver.sv
// Word-level front/back end for a bit-serial adder: streams operands LSB-first and reassembles the sum.
// Optional build macro SERIAL_DRIVER_STALL_EN adds the ser_stall input that freezes the serial stream.
module serial_adder_driver #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             ser_vld,
  output logic             ser_a,
  output logic             ser_b,
  output logic             ser_last,
  input  logic             ser_sum,
`ifdef SERIAL_DRIVER_STALL_EN
  input  logic             ser_stall,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh, b_sh, res;
  logic [CW-1:0]    cnt;
  logic             stall;
  logic             shift_en;

`ifdef SERIAL_DRIVER_STALL_EN
  assign stall = ser_stall;
`else
  assign stall = 1'b0;
`endif

  assign shift_en = (state_q == SHIFT) && !stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    ser_vld   = 1'b0;
    ser_a     = 1'b0;
    ser_b     = 1'b0;
    ser_last  = 1'b0;
    out_valid = 1'b0;
    out_sum   = '0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = SHIFT;
      end
      SHIFT: begin
        if (!stall) begin
          ser_vld  = 1'b1;
          ser_a    = a_sh[0];
          ser_b    = b_sh[0];
          ser_last = (cnt == LAST_IDX);
          if (cnt == LAST_IDX) state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        out_sum   = res;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The sum bit is combinational from the adder, so it is captured in the same cycle its operand bits are driven.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh <= '0;
      b_sh <= '0;
      res  <= '0;
      cnt  <= '0;
    end else if (state_q == IDLE && in_valid) begin
      a_sh <= in_a;
      b_sh <= in_b;
      res  <= '0;
      cnt  <= '0;
    end else if (shift_en) begin
      res[cnt] <= ser_sum;
      a_sh     <= a_sh >> 1;
      b_sh     <= b_sh >> 1;
      if (cnt != LAST_IDX) cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_serial_adder_driver.sv
// Self-checking bench for serial_adder_driver with a stub serial adder and a cycle-level protocol model.
module tb_serial_adder_driver;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [WIDTH-1:0] in_a, in_b, out_sum;
  logic             ser_vld, ser_a, ser_b, ser_last, ser_sum;
  logic             stall = 1'b0;

  serial_adder_driver #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .ser_vld(ser_vld), .ser_a(ser_a), .ser_b(ser_b),
    .ser_last(ser_last), .ser_sum(ser_sum),
`ifdef SERIAL_DRIVER_STALL_EN
    .ser_stall(stall),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum)
  );

  // stub bit-serial adder: carry cleared on vld&last and on reset
  logic carry;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       carry <= 1'b0;
    else if (ser_vld) carry <= ser_last ? 1'b0 : ((ser_a & ser_b) | (ser_a & carry) | (ser_b & carry));
  end
  assign ser_sum = ser_a ^ ser_b ^ carry;

  // WIDTH=1 instance
  logic       in1_valid, in1_ready, out1_valid, out1_ready;
  logic [0:0] in1_a, in1_b, out1_sum;
  logic       s1_vld, s1_a, s1_b, s1_last, s1_sum, carry1;
  logic       stall1 = 1'b0;

  serial_adder_driver #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in1_valid), .in_ready(in1_ready),
    .in_a(in1_a), .in_b(in1_b), .ser_vld(s1_vld), .ser_a(s1_a), .ser_b(s1_b),
    .ser_last(s1_last), .ser_sum(s1_sum),
`ifdef SERIAL_DRIVER_STALL_EN
    .ser_stall(stall1),
`endif
    .out_valid(out1_valid), .out_ready(out1_ready), .out_sum(out1_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      carry1 <= 1'b0;
    else if (s1_vld) carry1 <= s1_last ? 1'b0 : ((s1_a & s1_b) | (s1_a & carry1) | (s1_b & carry1));
  end
  assign s1_sum = s1_a ^ s1_b ^ carry1;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // Reference: phase 0 = waiting for operands, 1 = streaming bit bit_i, 2 = result pending.
  int               phase = 0;
  int               bit_i = 0;
  logic [WIDTH-1:0] ea, eb;
  logic             exp_vld;
  int               ops_done = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_ser_vld", ser_vld, 1'b0);
      chk("rst_ser_a", ser_a, 1'b0);
      chk("rst_ser_b", ser_b, 1'b0);
      chk("rst_ser_last", ser_last, 1'b0);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_sum", out_sum, '0);
      phase = 0;
    end else begin
      exp_vld = (phase == 1) && !stall;
      chk("in_ready", in_ready, phase == 0);
      chk("ser_vld", ser_vld, exp_vld);
      chk("ser_a", ser_a, exp_vld && ea[bit_i]);
      chk("ser_b", ser_b, exp_vld && eb[bit_i]);
      chk("ser_last", ser_last, exp_vld && (bit_i == WIDTH - 1));
      chk("out_valid", out_valid, phase == 2);
      if (phase == 2) chk("out_sum", out_sum, WIDTH'(ea + eb));
      if (phase == 0 && in_valid) begin
        phase = 1; bit_i = 0; ea = in_a; eb = in_b;
      end else if (phase == 1 && !stall) begin
        if (bit_i == WIDTH - 1) phase = 2;
        else bit_i++;
      end else if (phase == 2 && out_ready) begin
        phase = 0; ops_done++;
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    chk("idle_timeout", in_ready, 1'b1);
  endtask

  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] lit, input int hold);
    int n;
    logic [WIDTH-1:0] held;
    wait_idle();
    in_valid = 1'b1; in_a = a; in_b = b; out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = WIDTH'($urandom); in_b = WIDTH'($urandom);
    n = 0;
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    chk("result_timeout", out_valid, 1'b1);
    chk("lit_sum", out_sum, lit);
    if (hold > 0) begin
      held = out_sum;
      in_valid = 1'b1;
      repeat (hold) begin
        @(posedge clk); #1;
        chk("hold_sum", out_sum, held);
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_in_ready", in_ready, 1'b0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("hold_consumed", out_valid, 1'b0);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_a = '0; in_b = '0;
    in1_valid = 1'b0; out1_ready = 1'b1; in1_a = '0; in1_b = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    run_op(WIDTH'(8'h3C), WIDTH'(8'h0F), WIDTH'(8'h4B), 0);
    run_op(WIDTH'(8'hFF), WIDTH'(8'h01), WIDTH'(8'h00), 0);
    run_op(WIDTH'(8'h01), WIDTH'(8'h01), WIDTH'(8'h02), 0);
    run_op(WIDTH'(8'h77), WIDTH'(8'h22), WIDTH'(8'h99), 5);

`ifdef SERIAL_DRIVER_STALL_EN
    wait_idle();
    in_valid = 1'b1; in_a = WIDTH'(8'hA5); in_b = WIDTH'(8'h5A); out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      stall = (c == 3 || c == 8);
      @(posedge clk); #1;
    end
    stall = 1'b0;
    chk("stall_valid", out_valid, 1'b1);
    chk("stall_sum", out_sum, WIDTH'(8'hFF));
`endif

    // reset during bit 4
    wait_idle();
    in_valid = 1'b1; in_a = WIDTH'(8'h12); in_b = WIDTH'(8'h34);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("abort_ser_vld", ser_vld, 1'b0);
    chk("abort_ser_last", ser_last, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run_op(WIDTH'(8'h12), WIDTH'(8'h34), WIDTH'(8'h46), 0);

    // WIDTH=1: 1+1
    in1_valid = 1'b1; in1_a = 1'b1; in1_b = 1'b1;
    @(posedge clk); #1;
    in1_valid = 1'b0;
    chk("w1_vld", s1_vld, 1'b1);
    chk("w1_last", s1_last, 1'b1);
    @(posedge clk); #1;
    chk("w1_vld_after", s1_vld, 1'b0);
    chk("w1_out_valid", out1_valid, 1'b1);
    chk("w1_out_sum", out1_sum, 1'b0);
    @(posedge clk); #1;
    chk("w1_idle", in1_ready, 1'b1);

    // randomized traffic
    repeat (3000) begin
      @(posedge clk); #1;
      in_valid  = 1'($urandom_range(0, 1));
      in_a      = WIDTH'($urandom);
      in_b      = WIDTH'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
`ifdef SERIAL_DRIVER_STALL_EN
      stall     = ($urandom_range(0, 3) == 0);
`endif
    end
    in_valid = 1'b0; out_ready = 1'b1; stall = 1'b0;
    repeat (2 * WIDTH + 4) @(posedge clk);
    #1;
    chk("random_ops_progress", ops_done > 100, 1'b1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
